// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle instruction control FSM.
//
// Contents:
//   - opcode values of the decode table (4-bit)
//   - FSM state enum
//   - encodings of aluControlOp, regWrite and jumpBranch
//   - instruction class enum and the control word handed from the decoder to the FSM
package control_pkg;

    // Decode table
    localparam logic [3:0] OP_TYPE_A = 4'b1111;
    localparam logic [3:0] OP_ADDI   = 4'b0001;
    localparam logic [3:0] OP_ORI    = 4'b0010;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1011;
    localparam logic [3:0] OP_SB     = 4'b1010;
    localparam logic [3:0] OP_BLT    = 4'b0100;
    localparam logic [3:0] OP_BGT    = 4'b0101;
    localparam logic [3:0] OP_BEQ    = 4'b0110;
    localparam logic [3:0] OP_JMP    = 4'b1100;
    localparam logic [3:0] OP_HALT   = 4'b0000;

    // aluControlOp
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_OR     = 2'b10;
    localparam logic [1:0] ALU_MULDIV = 2'b11;

    // regWrite
    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_RD    = 2'b01;
    localparam logic [1:0] RW_RD_HI = 2'b10;

    // jumpBranch
    localparam logic [2:0] JB_NONE = 3'b000;
    localparam logic [2:0] JB_BLT  = 3'b001;
    localparam logic [2:0] JB_BGT  = 3'b010;
    localparam logic [2:0] JB_BEQ  = 3'b011;
    localparam logic [2:0] JB_JMP  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MULDIV = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Instruction class: selects the state path taken after DECODE.
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } iclass_t;

    // Static control word for one instruction; the FSM gates it per state.
    typedef struct packed {
        iclass_t    iclass;
        logic       alu_b_type;
        logic       alu_src;
        logic       zero_extend;
        logic       store_byte;
        logic [1:0] alu_op;
        logic [1:0] reg_write;
        logic [2:0] jump_branch;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/multiDiv to control-word decoder.
//
// Ports:
//   opcode     in   OPCODE_W  instruction opcode
//   multi_div  in   1         with TYPE_A, selects mul/div
//   ctrl       out  ctrl_t    instruction class and static controls
// Opcodes outside the decode table yield class CLS_ILLEGAL with all controls 0.
module control_decode
    import control_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                multi_div,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.iclass = CLS_ILLEGAL;
        case (opcode)
            OPCODE_W'(OP_TYPE_A): begin
                if (multi_div) begin
                    ctrl.iclass    = CLS_MULDIV;
                    ctrl.alu_op    = ALU_MULDIV;
                    ctrl.reg_write = RW_RD_HI;
                end else begin
                    ctrl.iclass    = CLS_ALU;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.reg_write = RW_RD;
                end
            end
            OPCODE_W'(OP_ADDI): begin
                ctrl.iclass    = CLS_ALU;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg_write = RW_RD;
            end
            OPCODE_W'(OP_ORI): begin
                ctrl.iclass      = CLS_ALU;
                ctrl.alu_src     = 1'b1;
                ctrl.zero_extend = 1'b1;
                ctrl.alu_op      = ALU_OR;
                ctrl.reg_write   = RW_RD;
            end
            OPCODE_W'(OP_LW): begin
                ctrl.iclass    = CLS_LOAD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = RW_RD;
            end
            OPCODE_W'(OP_SW): begin
                ctrl.iclass  = CLS_STORE;
                ctrl.alu_src = 1'b1;
            end
            OPCODE_W'(OP_SB): begin
                ctrl.iclass     = CLS_STORE;
                ctrl.alu_src    = 1'b1;
                ctrl.store_byte = 1'b1;
            end
            OPCODE_W'(OP_BLT): begin
                ctrl.iclass      = CLS_BRANCH;
                ctrl.alu_b_type  = 1'b1;
                ctrl.alu_op      = ALU_SUB;
                ctrl.jump_branch = JB_BLT;
            end
            OPCODE_W'(OP_BGT): begin
                ctrl.iclass      = CLS_BRANCH;
                ctrl.alu_b_type  = 1'b1;
                ctrl.alu_op      = ALU_SUB;
                ctrl.jump_branch = JB_BGT;
            end
            OPCODE_W'(OP_BEQ): begin
                ctrl.iclass      = CLS_BRANCH;
                ctrl.alu_b_type  = 1'b1;
                ctrl.alu_op      = ALU_SUB;
                ctrl.jump_branch = JB_BEQ;
            end
            // JMP is unconditional: no compare, so no B-type operand or SUB.
            OPCODE_W'(OP_JMP): begin
                ctrl.iclass      = CLS_BRANCH;
                ctrl.jump_branch = JB_JMP;
            end
            OPCODE_W'(OP_HALT): begin
                ctrl.iclass = CLS_HALT;
            end
            default: begin
                ctrl.iclass = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction control FSM. Accepts one instruction per handshake,
// sequences DECODE/EXEC/MULDIV/MEM/WB and drives registered datapath controls.
//
// Handshake: an instruction transfers in a cycle where instrValid & instrReady
// are both high; instrReady is high only in IDLE, so instrValid is ignored in
// every other state. opcode/multiDiv are decoded and captured on the transfer.
// memReady is looked at only in MEM.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instrValid/instrReady    instruction handshake
//   opcode, multiDiv         instruction, captured on transfer
//   memReady                 memory access complete (MEM only)
//   aluBType, aluSrc, zeroExtendFlag, memRead, memToReg, memWrite, storeByte,
//   aluControlOp[1:0], regWrite[1:0], jumpBranch[2:0]   registered controls
//   busy, halted             state != IDLE, state == HALT
//   trap                     illegal-opcode pulse during DECODE
//   dbg_state[2:0]           current FSM state (state_t encoding)
//
// Configuration macro: CONTROL_ILLEGAL_TRAP_EN. Defined: an illegal opcode
// pulses trap in its DECODE cycle and then enters HALT. Undefined: an illegal
// opcode runs as a NOP (DECODE>IDLE) and trap is tied 0.
module control_fsm
    import control_pkg::*;
#(
    parameter int OPCODE_W      = 4,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instrValid,
    output logic                instrReady,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                multiDiv,
    input  logic                memReady,
    output logic                aluBType,
    output logic                aluSrc,
    output logic                zeroExtendFlag,
    output logic                memRead,
    output logic                memToReg,
    output logic                memWrite,
    output logic                storeByte,
    output logic [1:0]          aluControlOp,
    output logic [1:0]          regWrite,
    output logic [2:0]          jumpBranch,
    output logic                busy,
    output logic                halted,
    output logic                trap,
    output logic [2:0]          dbg_state
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    ctrl_t            dec, ctrl_q;
    logic             transfer;

    // Next-cycle values of the registered controls.
    logic             in_op;
    logic             alu_b_type_d, alu_src_d, zero_ext_d;
    logic             mem_read_d, mem_to_reg_d, mem_write_d, store_byte_d;
    logic [1:0]       alu_op_d, reg_write_d;
    logic [2:0]       jump_branch_d;

    control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode    (opcode),
        .multi_div (multiDiv),
        .ctrl      (dec)
    );

    assign instrReady = (state == ST_IDLE);
    assign transfer   = instrValid & instrReady;
    assign busy       = (state != ST_IDLE);
    assign halted     = (state == ST_HALT);
    assign dbg_state  = state;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (instrValid) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (ctrl_q.iclass)
                    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: next_state = ST_EXEC;
                    CLS_MULDIV: begin
                        next_state = ST_MULDIV;
                        cnt_next   = CNT_W'(MULDIV_CYCLES - 1);
                    end
                    CLS_HALT: next_state = ST_HALT;
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    default: next_state = ST_HALT;
`else
                    default: next_state = ST_IDLE;
`endif
                endcase
            end
            ST_EXEC: begin
                case (ctrl_q.iclass)
                    CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                    CLS_ALU:             next_state = ST_WB;
                    default:             next_state = ST_IDLE;
                endcase
            end
            ST_MULDIV: begin
                // Counter holds the remaining MULDIV cycles after this one.
                if (cnt == '0) next_state = ST_WB;
                else           cnt_next   = cnt - 1'b1;
            end
            ST_MEM: begin
                if (memReady) next_state = (ctrl_q.iclass == CLS_LOAD) ? ST_WB : ST_IDLE;
            end
            ST_WB:   next_state = ST_IDLE;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_IDLE;
        endcase
    end

    // Controls are registered from next_state, so each output lines up with
    // the state it belongs to. ALU controls hold from the first state after
    // DECODE through the last state of the instruction; the remaining strobes
    // are confined to their own state.
    always_comb begin
        in_op = (next_state == ST_EXEC) || (next_state == ST_MULDIV) ||
                (next_state == ST_MEM)  || (next_state == ST_WB);
        alu_b_type_d  = in_op & ctrl_q.alu_b_type;
        alu_src_d     = in_op & ctrl_q.alu_src;
        zero_ext_d    = in_op & ctrl_q.zero_extend;
        alu_op_d      = in_op ? ctrl_q.alu_op : ALU_ADD;
        jump_branch_d = (next_state == ST_EXEC) ? ctrl_q.jump_branch : JB_NONE;
        mem_read_d    = (next_state == ST_MEM) && (ctrl_q.iclass == CLS_LOAD);
        mem_write_d   = (next_state == ST_MEM) && (ctrl_q.iclass == CLS_STORE);
        store_byte_d  = mem_write_d & ctrl_q.store_byte;
        mem_to_reg_d  = (next_state == ST_WB) && (ctrl_q.iclass == CLS_LOAD);
        reg_write_d   = (next_state == ST_WB) ? ctrl_q.reg_write : RW_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            ctrl_q         <= '0;
            aluBType       <= 1'b0;
            aluSrc         <= 1'b0;
            zeroExtendFlag <= 1'b0;
            memRead        <= 1'b0;
            memToReg       <= 1'b0;
            memWrite       <= 1'b0;
            storeByte      <= 1'b0;
            aluControlOp   <= ALU_ADD;
            regWrite       <= RW_NONE;
            jumpBranch     <= JB_NONE;
        end else begin
            state          <= next_state;
            cnt            <= cnt_next;
            if (transfer) ctrl_q <= dec;
            aluBType       <= alu_b_type_d;
            aluSrc         <= alu_src_d;
            zeroExtendFlag <= zero_ext_d;
            memRead        <= mem_read_d;
            memToReg       <= mem_to_reg_d;
            memWrite       <= mem_write_d;
            storeByte      <= store_byte_d;
            aluControlOp   <= alu_op_d;
            regWrite       <= reg_write_d;
            jumpBranch     <= jump_branch_d;
        end
    end

`ifdef CONTROL_ILLEGAL_TRAP_EN
    // Decoded straight from the incoming opcode so the pulse lands in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trap <= 1'b0;
        else     trap <= transfer && (dec.iclass == CLS_ILLEGAL);
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

    localparam int MD = 4;

    typedef struct packed {
        logic       ready, busy, halted, trap;
        logic       b_type, alu_src, zext, mem_read, mem_to_reg, mem_write, store_byte;
        logic [1:0] alu_op;
        logic [1:0] reg_write;
        logic [2:0] jb;
    } outs_t;

    typedef struct {
        logic [3:0] op;
        logic       md;
        int         wait_n;
        int         busy_n, rw_val, rw_n, mem_n, jb_val;
        string      name;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       instrValid = 1'b0, multiDiv = 1'b0, memReady = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       instrReady, aluBType, aluSrc, zeroExtendFlag, memRead, memToReg;
    logic       memWrite, storeByte, busy, halted, trap;
    logic [1:0] aluControlOp, regWrite;
    logic [2:0] jumpBranch, dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [17:0] exp_q[$];
    logic [1:0]  mem_q[$];   // {cycle is MEM, memReady to drive}

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    control_fsm dut (
        .clk(clk), .rst(rst), .instrValid(instrValid), .instrReady(instrReady),
        .opcode(opcode), .multiDiv(multiDiv), .memReady(memReady),
        .aluBType(aluBType), .aluSrc(aluSrc), .zeroExtendFlag(zeroExtendFlag),
        .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite),
        .storeByte(storeByte), .aluControlOp(aluControlOp), .regWrite(regWrite),
        .jumpBranch(jumpBranch), .busy(busy), .halted(halted), .trap(trap),
        .dbg_state(dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic outs_t cur();
        outs_t o;
        o = '{instrReady, busy, halted, trap, aluBType, aluSrc, zeroExtendFlag,
              memRead, memToReg, memWrite, storeByte, aluControlOp, regWrite, jumpBranch};
        return o;
    endfunction

    function automatic outs_t idle_o();
        outs_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push(input outs_t o, input logic is_mem, input logic mr);
        exp_q.push_back(o);
        mem_q.push_back({is_mem, mr});
    endtask

    // Expected outputs for each cycle after the transfer cycle, straight from
    // the instruction's path through the pipeline phases.
    task automatic build_expect(input logic [3:0] op, input logic md, input int wait_n);
        outs_t base, ctl, o;
        logic is_alu, is_md, is_lw, is_st, is_br, is_jmp, is_halt, is_ill;
        is_alu  = (op == 4'b1111 && !md) || op == 4'b0001 || op == 4'b0010;
        is_md   = (op == 4'b1111 && md);
        is_lw   = (op == 4'b1000);
        is_st   = (op == 4'b1011) || (op == 4'b1010);
        is_br   = (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0110);
        is_jmp  = (op == 4'b1100);
        is_halt = (op == 4'b0000);
        is_ill  = !(is_alu || is_md || is_lw || is_st || is_br || is_jmp || is_halt);
        base = '0;
        base.busy = 1'b1;
        ctl = base;
        ctl.b_type  = is_br;
        ctl.alu_src = (op == 4'b0001) || (op == 4'b0010) || is_lw || is_st;
        ctl.zext    = (op == 4'b0010);
        ctl.alu_op  = is_md ? 2'b11 : is_br ? 2'b01 : (op == 4'b0010) ? 2'b10 : 2'b00;
        o = base;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        o.trap = is_ill;
`endif
        push(o, 1'b0, 1'b0);                                   // DECODE
        if (is_alu) begin
            push(ctl, 1'b0, 1'b0);
            o = ctl; o.reg_write = 2'b01; push(o, 1'b0, 1'b0);
        end else if (is_md) begin
            for (int i = 0; i < MD; i++) push(ctl, 1'b0, 1'b0);
            o = ctl; o.reg_write = 2'b10; push(o, 1'b0, 1'b0);
        end else if (is_lw) begin
            push(ctl, 1'b0, 1'b0);
            for (int i = 0; i <= wait_n; i++) begin
                o = ctl; o.mem_read = 1'b1; push(o, 1'b1, i == wait_n);
            end
            o = ctl; o.mem_to_reg = 1'b1; o.reg_write = 2'b01; push(o, 1'b0, 1'b0);
        end else if (is_st) begin
            push(ctl, 1'b0, 1'b0);
            for (int i = 0; i <= wait_n; i++) begin
                o = ctl; o.mem_write = 1'b1; o.store_byte = (op == 4'b1010);
                push(o, 1'b1, i == wait_n);
            end
        end else if (is_br || is_jmp) begin
            o = ctl;
            o.jb = (op == 4'b0100) ? 3'd1 : (op == 4'b0101) ? 3'd2 : (op == 4'b0110) ? 3'd3 : 3'd4;
            push(o, 1'b0, 1'b0);
        end else begin
            logic stops;
            stops = is_halt;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            stops = 1'b1;
`endif
            if (stops) begin
                o = '0; o.busy = 1'b1; o.halted = 1'b1;
                repeat (3) push(o, 1'b0, 1'b0);
            end
        end
    endtask

    // ---------------- driver: one instruction against the model ----------------
    task automatic run_instr(input string tag, input logic [3:0] op, input logic md,
                             input int wait_n, input logic noise);
        logic [17:0] e;
        logic [1:0]  m;
        int k;
        build_expect(op, md, wait_n);
        check({tag, " accept"}, cur(), idle_o());
        instrValid = 1'b1; opcode = op; multiDiv = md;
        memReady = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        k = 1;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            m = mem_q.pop_front();
            check($sformatf("%s c%0d", tag, k), cur(), e);
            instrValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                opcode   = 4'($urandom_range(0, 15));
                multiDiv = 1'($urandom_range(0, 1));
            end
            memReady = m[1] ? m[0] : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            k++;
        end
        tick();
        instrValid = 1'b0;
        memReady   = 1'b0;
    endtask

    // Runs one instruction with quiet inputs and counts what the outputs did.
    task automatic run_measure(input logic [3:0] op, input logic md, input int wait_n,
                               output int busy_n, output int rw_val, output int rw_n,
                               output int mem_n, output int jb_val);
        int seen;
        int guard;
        busy_n = 0; rw_val = 0; rw_n = 0; mem_n = 0; jb_val = 0; seen = 0; guard = 0;
        instrValid = 1'b1; opcode = op; multiDiv = md; memReady = 1'b0;
        tick();
        instrValid = 1'b0;
        while (busy && guard < 60) begin
            guard++;
            busy_n++;
            if (regWrite != 2'b00) begin rw_n++; rw_val = int'(regWrite); end
            if (jumpBranch != 3'b000) jb_val = int'(jumpBranch);
            if (memRead || memWrite) begin
                memReady = (seen == wait_n);
                seen++;
                mem_n++;
            end else begin
                memReady = 1'b0;
            end
            tick();
        end
        memReady = 1'b0;
        check_val("measure bound", int'(guard < 60), 1);
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl[$];
    logic [3:0] pool[$];

    initial begin
        outs_t o;
        int b, rv, rn, mn, jv;

        // reset
        tick(); tick();
        check("reset held", cur(), idle_o());
        rst = 1'b0;
        tick();
        check("reset released", cur(), idle_o());

        // table: op md wait | busy rw_val rw_n mem_n jb_val
        tbl.push_back('{4'b0001, 1'b0, 0, 3, 1, 1, 0, 0, "ADDI"});
        tbl.push_back('{4'b0010, 1'b0, 0, 3, 1, 1, 0, 0, "ORI"});
        tbl.push_back('{4'b1111, 1'b0, 0, 3, 1, 1, 0, 0, "TYPEA"});
        tbl.push_back('{4'b1111, 1'b1, 0, 6, 2, 1, 0, 0, "MULDIV"});
        tbl.push_back('{4'b1000, 1'b0, 3, 7, 1, 1, 4, 0, "LW w3"});
        tbl.push_back('{4'b1000, 1'b0, 0, 4, 1, 1, 1, 0, "LW w0"});
        tbl.push_back('{4'b1011, 1'b0, 2, 5, 0, 0, 3, 0, "SW w2"});
        tbl.push_back('{4'b1010, 1'b0, 0, 3, 0, 0, 1, 0, "SB w0"});
        tbl.push_back('{4'b0100, 1'b0, 0, 2, 0, 0, 0, 1, "BLT"});
        tbl.push_back('{4'b0101, 1'b0, 0, 2, 0, 0, 0, 2, "BGT"});
        tbl.push_back('{4'b0110, 1'b0, 0, 2, 0, 0, 0, 3, "BEQ"});
        tbl.push_back('{4'b1100, 1'b0, 0, 2, 0, 0, 0, 4, "JMP"});
`ifndef CONTROL_ILLEGAL_TRAP_EN
        tbl.push_back('{4'b0011, 1'b0, 0, 1, 0, 0, 0, 0, "ILL nop"});
`endif
        foreach (tbl[i]) begin
            run_measure(tbl[i].op, tbl[i].md, tbl[i].wait_n, b, rv, rn, mn, jv);
            check_val({tbl[i].name, " busy"}, b, tbl[i].busy_n);
            check_val({tbl[i].name, " rw_val"}, rv, tbl[i].rw_val);
            check_val({tbl[i].name, " rw_n"}, rn, tbl[i].rw_n);
            check_val({tbl[i].name, " mem_n"}, mn, tbl[i].mem_n);
            check_val({tbl[i].name, " jb"}, jv, tbl[i].jb_val);
        end

        // cycle-exact sequences
        run_instr("ADDI", 4'b0001, 1'b0, 0, 1'b0);
        run_instr("MULDIV", 4'b1111, 1'b1, 0, 1'b0);
        run_instr("LW", 4'b1000, 1'b0, 3, 1'b0);
        run_instr("SB", 4'b1010, 1'b0, 2, 1'b0);
        run_instr("BEQ", 4'b0110, 1'b0, 0, 1'b0);

        // reset in the middle of MULDIV
        instrValid = 1'b1; opcode = 4'b1111; multiDiv = 1'b1;
        tick();
        instrValid = 1'b0;
        tick(); tick();
        o = '0; o.busy = 1'b1; o.alu_op = 2'b11;
        check("muldiv before rst", cur(), o);
        rst = 1'b1;
        #1;
        check("rst async abort", cur(), idle_o());
        tick();
        rst = 1'b0;
        tick();
        check("after rst release", cur(), idle_o());
        tick();
        check("no partial wb", cur(), idle_o());
        run_instr("ADDI post-rst", 4'b0001, 1'b0, 0, 1'b0);

        // illegal opcode
        run_instr("ILL", 4'b0011, 1'b0, 0, 1'b0);
`ifdef CONTROL_ILLEGAL_TRAP_EN
        o = '0; o.busy = 1'b1; o.halted = 1'b1;
        instrValid = 1'b1; opcode = 4'b0001;
        repeat (3) begin tick(); check("trap halt ignores valid", cur(), o); end
        instrValid = 1'b0;
        rst = 1'b1; #1;
        check("trap halt rst", cur(), idle_o());
        tick(); rst = 1'b0; tick();
`endif

        // HALT opcode: terminal until reset
        run_instr("HALT", 4'b0000, 1'b0, 0, 1'b1);
        o = '0; o.busy = 1'b1; o.halted = 1'b1;
        instrValid = 1'b1; opcode = 4'b0001;
        repeat (3) begin tick(); check("halt ignores valid", cur(), o); end
        instrValid = 1'b0;
        rst = 1'b1; #1;
        check("halt rst", cur(), idle_o());
        tick(); rst = 1'b0; tick();

        // randomized instructions with noisy ignored inputs
        pool = '{4'b1111, 4'b0001, 4'b0010, 4'b1000, 4'b1011, 4'b1010,
                 4'b0100, 4'b0101, 4'b0110, 4'b1100};
`ifndef CONTROL_ILLEGAL_TRAP_EN
        pool.push_back(4'b0011); pool.push_back(4'b0111);
        pool.push_back(4'b1001); pool.push_back(4'b1110);
`endif
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            op = pool[$urandom_range(0, pool.size() - 1)];
            run_instr($sformatf("rnd%0d op%b", n, op), op, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                memReady = 1'($urandom_range(0, 1));
                tick();
                check("rnd idle gap", cur(), idle_o());
            end
            memReady = 1'b0;
        end

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
